// File: rtl/sign_streak_monitor.sv
// Tracks same-sign runs from the mutex sign classifier, locks on a confirmed
// streak, counts confirmed lock reversals and latches a sticky mutex fault.
module sign_streak_monitor #(
    parameter int STREAK_LEN = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             positive_flag,
    input  logic             negative_flag,
    output logic             pos_locked,
    output logic             neg_locked,
    output logic [CNT_W-1:0] run_len,
    output logic             sign_change,
    output logic [CNT_W-1:0] flip_count,
    output logic             mutex_err
);

    typedef enum logic [2:0] {
        NEUTRAL  = 3'd0,
        POS_PEND = 3'd1,
        POS_LOCK = 3'd2,
        NEG_PEND = 3'd3,
        NEG_LOCK = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] STREAK_CNT = CNT_W'(STREAK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t           state_r;
    logic             last_valid_r;
    logic             last_pos_r;
    logic             is_p_s;
    logic             is_n_s;
    logic             is_x_s;
    logic [CNT_W-1:0] pos_run_s;
    logic [CNT_W-1:0] neg_run_s;

    assign is_p_s = positive_flag & ~negative_flag;
    assign is_n_s = negative_flag & ~positive_flag;
    assign is_x_s = positive_flag & negative_flag;

    // Candidate run length if this sample extends (or restarts) a run of each sign
    always_comb begin
        pos_run_s = CNT_ONE;
        neg_run_s = CNT_ONE;
        if ((state_r == POS_PEND || state_r == POS_LOCK) && run_len != CNT_ZERO) begin
            pos_run_s = sat_inc(run_len);
        end else begin
            pos_run_s = CNT_ONE;
        end
        if ((state_r == NEG_PEND || state_r == NEG_LOCK) && run_len != CNT_ZERO) begin
            neg_run_s = sat_inc(run_len);
        end else begin
            neg_run_s = CNT_ONE;
        end
    end

    // Streak state machine with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= NEUTRAL;
            last_valid_r <= 1'b0;
            last_pos_r   <= 1'b0;
            pos_locked   <= 1'b0;
            neg_locked   <= 1'b0;
            run_len      <= CNT_ZERO;
            sign_change  <= 1'b0;
            flip_count   <= CNT_ZERO;
            mutex_err    <= 1'b0;
        end else begin
            sign_change <= 1'b0;
            case (state_r)
                FAULT: begin
                    state_r    <= FAULT;
                    pos_locked <= 1'b0;
                    neg_locked <= 1'b0;
                    run_len    <= CNT_ZERO;
                    mutex_err  <= 1'b1;
                end
                default: begin
                    if (is_x_s) begin
                        state_r      <= FAULT;
                        mutex_err    <= 1'b1;
                        pos_locked   <= 1'b0;
                        neg_locked   <= 1'b0;
                        run_len      <= CNT_ZERO;
                        last_valid_r <= 1'b0;
                        last_pos_r   <= 1'b0;
                    end else if (is_p_s) begin
                        run_len    <= pos_run_s;
                        neg_locked <= 1'b0;
                        if (state_r == POS_LOCK) begin
                            pos_locked <= 1'b1;
                        end else if (pos_run_s >= STREAK_CNT) begin
                            state_r      <= POS_LOCK;
                            pos_locked   <= 1'b1;
                            last_valid_r <= 1'b1;
                            last_pos_r   <= 1'b1;
                            // A reversal only counts against a previous lock of the other sign
                            if (last_valid_r && !last_pos_r) begin
                                sign_change <= 1'b1;
                                flip_count  <= sat_inc(flip_count);
                            end else begin
                                sign_change <= 1'b0;
                            end
                        end else begin
                            state_r    <= POS_PEND;
                            pos_locked <= 1'b0;
                        end
                    end else if (is_n_s) begin
                        run_len    <= neg_run_s;
                        pos_locked <= 1'b0;
                        if (state_r == NEG_LOCK) begin
                            neg_locked <= 1'b1;
                        end else if (neg_run_s >= STREAK_CNT) begin
                            state_r      <= NEG_LOCK;
                            neg_locked   <= 1'b1;
                            last_valid_r <= 1'b1;
                            last_pos_r   <= 1'b0;
                            if (last_valid_r && last_pos_r) begin
                                sign_change <= 1'b1;
                                flip_count  <= sat_inc(flip_count);
                            end else begin
                                sign_change <= 1'b0;
                            end
                        end else begin
                            state_r    <= NEG_PEND;
                            neg_locked <= 1'b0;
                        end
                    end else begin
                        // Zero sample: locks ride through, pending runs are abandoned
                        run_len <= CNT_ZERO;
                        if (state_r == POS_LOCK || state_r == NEG_LOCK) begin
                            state_r <= state_r;
                        end else begin
                            state_r <= NEUTRAL;
                        end
                    end
                end
            endcase
        end
    end

endmodule
